fir_filter_mac: RTL and testbench

//   Parametrised signed FIR filter using one time-shared multiply-accumulate unit.

---
 rtl/fir_filter_mac.sv | 152 +++++++++++++++
 tb/tb_fir_filter_mac.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// Signed FIR filter built around a single time-shared multiply-accumulate unit.
// Accepts one sample per TAPS+2 cycles, rounds, saturates and reports clipping.
module fir_filter_mac #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned COEF_W    = 8,
   parameter int unsigned TAPS      = 8,
   parameter int unsigned OUT_SHIFT = 6
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic signed [DATA_W-1:0]   x_i,
   input  logic                       x_valid_i,
   output logic                       x_ready_o,
   input  logic                       flush_i,
   input  logic                       coef_we_i,
   input  logic [$clog2(TAPS)-1:0]    coef_addr_i,
   input  logic signed [COEF_W-1:0]   coef_data_i,
   output logic signed [DATA_W-1:0]   y_o,
   output logic                       y_valid_o,
   output logic                       sat_o,
   output logic                       busy_o
);

   localparam int unsigned ADDR_W = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

   localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (OUT_SHIFT - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX    = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN    = ~Y_MAX;
   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) << OUT_SHIFT;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

   state_e                    state_q, state_d;
   logic signed [DATA_W-1:0]  d_q    [TAPS];
   logic signed [DATA_W-1:0]  d_d    [TAPS];
   logic signed [COEF_W-1:0]  coef_q [TAPS];
   logic signed [COEF_W-1:0]  coef_d [TAPS];
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [ADDR_W-1:0]         idx_q, idx_d;
   logic signed [DATA_W-1:0]  y_q, y_d;
   logic                      y_valid_q, y_valid_d;
   logic                      sat_q, sat_d;
   logic                      ready_q, ready_d;
   logic                      busy_q, busy_d;

   logic                      accept_c;
   logic signed [PROD_W-1:0]  prod_c;
   logic signed [ACC_W-1:0]   rnd_c;
   logic signed [ACC_W-1:0]   shr_c;

   assign accept_c = x_valid_i && ready_q;
   assign prod_c   = d_q[idx_q] * coef_q[idx_q];
   assign rnd_c    = acc_q + RND;
   assign shr_c    = rnd_c >>> OUT_SHIFT;

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept_c) state_d = S_MAC;
         S_MAC:   if (idx_q == LAST_IDX) state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      d_d       = d_q;
      coef_d    = coef_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      y_d       = y_q;
      y_valid_d = 1'b0;
      sat_d     = 1'b0;
      ready_d   = (state_d == S_IDLE);
      busy_d    = (state_d != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (coef_we_i && (32'(coef_addr_i) < TAPS)) coef_d[coef_addr_i] = coef_data_i;
            if (accept_c) begin
               d_d[0] = x_i;
               for (int k = 1; k < int'(TAPS); k++) d_d[k] = d_q[k-1];
               acc_d = '0;
               idx_d = '0;
            end else if (flush_i) begin
               for (int k = 0; k < int'(TAPS); k++) d_d[k] = '0;
            end
         end
         S_MAC: begin
            acc_d = acc_q + ACC_W'(prod_c);
            idx_d = idx_q + ADDR_W'(1);
         end
         S_OUT: begin
            y_valid_d = 1'b1;
            if (shr_c > Y_MAX) begin
               y_d   = DATA_W'(Y_MAX);
               sat_d = 1'b1;
            end else if (shr_c < Y_MIN) begin
               y_d   = DATA_W'(Y_MIN);
               sat_d = 1'b1;
            end else begin
               y_d   = DATA_W'(shr_c);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; coefficients reset to an identity filter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            d_q[k]    <= '0;
            coef_q[k] <= (k == 0) ? COEF_ONE : '0;
         end
         acc_q     <= '0;
         idx_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         sat_q     <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         d_q       <= d_d;
         coef_q    <= coef_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         sat_q     <= sat_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   assign x_ready_o = ready_q;
   assign y_o       = y_q;
   assign y_valid_o = y_valid_q;
   assign sat_o     = sat_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac (8-bit data/coefs, 8 taps, shift 6).
module tb_fir_filter_mac;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] x_i;
   logic       x_valid_i;
   logic       x_ready_o;
   logic       flush_i;
   logic       coef_we_i;
   logic [2:0] coef_addr_i;
   logic [7:0] coef_data_i;
   logic [7:0] y_o;
   logic       y_valid_o;
   logic       sat_o;
   logic       busy_o;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   fir_filter_mac #(.DATA_W(8), .COEF_W(8), .TAPS(8), .OUT_SHIFT(6)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .x_i        (x_i),
      .x_valid_i  (x_valid_i),
      .x_ready_o  (x_ready_o),
      .flush_i    (flush_i),
      .coef_we_i  (coef_we_i),
      .coef_addr_i(coef_addr_i),
      .coef_data_i(coef_data_i),
      .y_o        (y_o),
      .y_valid_o  (y_valid_o),
      .sat_o      (sat_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic coef_wr(input int a, input int v);
      coef_we_i   = 1'b1;
      coef_addr_i = 3'(a);
      coef_data_i = 8'(v);
      @(negedge clk);
      coef_we_i   = 1'b0;
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
   endtask

   // Present one sample, wait for its result; lat counts cycles from the accept cycle.
   task automatic run(input logic [7:0] x, output logic [7:0] y, output logic s, output int lat);
      int w;
      w = 0;
      x_i = x;
      x_valid_i = 1'b1;
      while (!x_ready_o && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", 32'(w), 32'd0);
      @(negedge clk);
      x_valid_i = 1'b0;
      lat = 1;
      while (!y_valid_o && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      y = y_o;
      s = sat_o;
   endtask

   initial begin
      logic [7:0] y;
      logic       s;
      int         lat;
      int         lows;
      int         nv;

      reset = 1'b1; x_i = '0; x_valid_i = 1'b0; flush_i = 1'b0;
      coef_we_i = 1'b0; coef_addr_i = '0; coef_data_i = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_y",     32'(y_o),       32'h00);
      chk("rst_yv",    32'(y_valid_o), 32'd0);
      chk("rst_sat",   32'(sat_o),     32'd0);
      chk("rst_busy",  32'(busy_o),    32'd0);
      chk("rst_ready", 32'(x_ready_o), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // Identity filter straight out of reset
      run(8'h10, y, s, lat);
      chk("id_y",   32'(y),   32'h10);
      chk("id_sat", 32'(s),   32'd0);
      chk("id_lat", 32'(lat), 32'd10);
      @(negedge clk);
      chk("id_pulse", 32'(y_valid_o), 32'd0);

      // Impulse response with coef[k]=k+1
      do_flush();
      for (int k = 0; k < 8; k++) coef_wr(k, k + 1);
      for (int i = 0; i < 9; i++) begin
         run((i == 0) ? 8'h40 : 8'h00, y, s, lat);
         chk($sformatf("imp_y%0d", i), 32'(y), (i < 8) ? 32'(i + 1) : 32'd0);
      end

      // Saturation, all coefs = 1.0
      for (int k = 0; k < 8; k++) coef_wr(k, 8'h40);
      do_flush();
      run(8'h7F, y, s, lat);
      chk("sat_first_y", 32'(y), 32'h7F);
      chk("sat_first_s", 32'(s), 32'd0);
      for (int i = 0; i < 7; i++) run(8'h7F, y, s, lat);
      chk("sat_pos_y", 32'(y), 32'h7F);
      chk("sat_pos_s", 32'(s), 32'd1);
      for (int i = 0; i < 8; i++) run(8'h80, y, s, lat);
      chk("sat_neg_y", 32'(y), 32'h80);
      chk("sat_neg_s", 32'(s), 32'd1);

      // Handshake with valid held high; a coef write while busy must be dropped
      coef_wr(0, 8'h40);
      for (int k = 1; k < 8; k++) coef_wr(k, 0);
      do_flush();
      x_i = 8'd1;
      x_valid_i = 1'b1;
      for (int v = 1; v <= 3; v++) begin
         @(negedge clk);
         lows = 0;
         while (!x_ready_o && lows < 30) begin
            lows++;
            coef_we_i   = (lows == 3);
            coef_addr_i = 3'd0;
            coef_data_i = 8'h20;
            @(negedge clk);
         end
         coef_we_i = 1'b0;
         chk($sformatf("hs_lows%0d", v), 32'(lows), 32'd9);
         chk($sformatf("hs_yv%0d", v),   32'(y_valid_o), 32'd1);
         chk($sformatf("hs_y%0d", v),    32'(y_o), 32'(v));
         if (v == 3) x_valid_i = 1'b0;
         else        x_i = 8'(v + 1);
      end
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (y_valid_o) nv++;
      end
      chk("hs_no_dup", 32'(nv), 32'd0);

      // Reset during the third MAC cycle
      coef_wr(0, 8'h20);
      x_i = 8'h10;
      x_valid_i = 1'b1;
      @(negedge clk);
      x_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mr_busy_before", 32'(busy_o), 32'd1);
      reset = 1'b1;
      #1;
      chk("mr_y",     32'(y_o),       32'h00);
      chk("mr_ready", 32'(x_ready_o), 32'd1);
      chk("mr_busy",  32'(busy_o),    32'd0);
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (y_valid_o) nv++;
      end
      chk("mr_no_out", 32'(nv), 32'd0);
      run(8'h10, y, s, lat);
      chk("mr_identity", 32'(y), 32'h10);

      // Flush in IDLE clears history but keeps coefs
      coef_wr(1, 8'h40);
      run(8'h20, y, s, lat);
      chk("fl_pre", 32'(y), 32'h30);
      do_flush();
      run(8'h00, y, s, lat);
      chk("fl_post", 32'(y), 32'h00);

      // Coef write in the accept cycle applies to that sample
      coef_we_i   = 1'b1;
      coef_addr_i = 3'd0;
      coef_data_i = 8'h20;
      run(8'h40, y, s, lat);
      coef_we_i   = 1'b0;
      chk("wr_accept", 32'(y), 32'h20);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
